// File: rtl/decode_pkg.sv
// Shared definitions for the decode->execute pipeline register:
// default jump opcodes, jump_kind encodings and the holding-FSM state encodings.
package decode_pkg;

  localparam int unsigned OPC_W_DEF  = 5;
  localparam int unsigned KIND_W     = 2;

  localparam logic [OPC_W_DEF-1:0] JR_OPC_DEF   = 5'b01101;
  localparam logic [OPC_W_DEF-1:0] JPC_OPC_DEF  = 5'b01110;
  localparam logic [OPC_W_DEF-1:0] CALL_OPC_DEF = 5'b10000;

  typedef enum logic [KIND_W-1:0] {
    JK_NONE = 2'd0,
    JK_JR   = 2'd1,
    JK_JPC  = 2'd2,
    JK_CALL = 2'd3
  } jump_kind_e;

  // EMPTY: nothing held; ONE: main entry valid; FULL: main + skid valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/decode_jump_classify.sv
// Combinational jump classifier.
// Ports:
//   inst    in   DWIDTH  instruction word
//   r_c     out  REG_W   jump register field, 0 when not a jump
//   kind_c  out  2       jump_kind encoding (none/JR/JPC/CALL)
module decode_jump_classify
  import decode_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned OPC_MSB = 31,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned REG_LSB = 10,
  parameter int unsigned REG_W   = 5,
  parameter logic [OPC_W-1:0] JR_OPC   = OPC_W'(JR_OPC_DEF),
  parameter logic [OPC_W-1:0] JPC_OPC  = OPC_W'(JPC_OPC_DEF),
  parameter logic [OPC_W-1:0] CALL_OPC = OPC_W'(CALL_OPC_DEF)
) (
  input  logic [DWIDTH-1:0] inst,
  output logic [REG_W-1:0]  r_c,
  output jump_kind_e        kind_c
);

  logic [OPC_W-1:0] opc;
  logic             unused_inst_bits;

  // Only the opcode and register fields matter here
  assign unused_inst_bits = ^inst;

  // Opcode match, then expose the register field only for jumps
  always_comb begin
    opc    = inst[OPC_MSB -: OPC_W];
    kind_c = JK_NONE;
    r_c    = '0;
    if (opc == JR_OPC)        kind_c = JK_JR;
    else if (opc == JPC_OPC)  kind_c = JK_JPC;
    else if (opc == CALL_OPC) kind_c = JK_CALL;
    if (kind_c != JK_NONE) r_c = inst[REG_LSB +: REG_W];
  end

endmodule

// File: rtl/decode_pipe_reg.sv
// IF/ID -> EX pipeline register with valid/ready handshake, 2-entry skid
// buffer (full throughput with a registered in_ready), flush and jump
// classification stored alongside each entry.
// Ports:
//   clk, rst (sync, active-low), flush
//   in_valid/in_ready, addr/immed/inst/rd1/rd2     upstream beat
//   out_valid/out_ready, stored_*                   downstream beat
//   R, jump_kind                                    classification of held beat
module decode_pipe_reg
  import decode_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned OPC_MSB = 31,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned REG_LSB = 10,
  parameter int unsigned REG_W   = 5,
  parameter logic [OPC_W-1:0] JR_OPC   = OPC_W'(JR_OPC_DEF),
  parameter logic [OPC_W-1:0] JPC_OPC  = OPC_W'(JPC_OPC_DEF),
  parameter logic [OPC_W-1:0] CALL_OPC = OPC_W'(CALL_OPC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] immed,
  input  logic [DWIDTH-1:0] inst,
  input  logic [DWIDTH-1:0] rd1,
  input  logic [DWIDTH-1:0] rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] stored_addr,
  output logic [DWIDTH-1:0] stored_immed,
  output logic [DWIDTH-1:0] stored_inst,
  output logic [DWIDTH-1:0] stored_rd1,
  output logic [DWIDTH-1:0] stored_rd2,
  output logic [REG_W-1:0]  R,
  output logic [1:0]        jump_kind
);

  // Entry layout: {addr, immed, inst, rd1, rd2, R, jump_kind}
  localparam int unsigned CLS_W = REG_W + KIND_W;
  localparam int unsigned PW    = 5 * DWIDTH + CLS_W;

  state_e          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   in_pl;
  logic            out_valid_d, in_ready_d;
  logic            accept, pop;
  logic [REG_W-1:0] cls_r;
  jump_kind_e      cls_kind;

  decode_jump_classify #(
    .DWIDTH  (DWIDTH),
    .OPC_MSB (OPC_MSB),
    .OPC_W   (OPC_W),
    .REG_LSB (REG_LSB),
    .REG_W   (REG_W),
    .JR_OPC  (JR_OPC),
    .JPC_OPC (JPC_OPC),
    .CALL_OPC(CALL_OPC)
  ) u_classify (
    .inst  (inst),
    .r_c   (cls_r),
    .kind_c(cls_kind)
  );

  assign in_pl = {addr, immed, inst, rd1, rd2, cls_r, cls_kind};

  // Main entry drives the outputs directly
  assign {stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2, R, jump_kind} = main_q;

  // Next-state, entry movement and registered handshake outputs
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = in_valid & in_ready;
    pop     = out_valid & out_ready;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_pl;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d = in_pl;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_pl;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can move things
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops everything, including a beat accepted this cycle
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = {main_q[PW-1:CLS_W], CLS_W'(0)};
      skid_d  = skid_q;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // State and payload registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Self-checking bench for decode_pipe_reg: directed scenarios plus a random
// run, all compared against a queue-based model of a 2-deep FIFO.
module tb_decode_pipe_reg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] immed;
    logic [31:0] inst;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] addr, immed, inst, rd1, rd2;
  logic [31:0] stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2;
  logic [4:0]  R;
  logic [1:0]  jump_kind;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t q[$];
  beat_t cur_in;
  bit    zero_all;
  bit    class_zero;

  always #5 clk = ~clk;

  decode_pipe_reg dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .addr        (addr),
    .immed       (immed),
    .inst        (inst),
    .rd1         (rd1),
    .rd2         (rd2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .stored_addr (stored_addr),
    .stored_immed(stored_immed),
    .stored_inst (stored_inst),
    .stored_rd1  (stored_rd1),
    .stored_rd2  (stored_rd2),
    .R           (R),
    .jump_kind   (jump_kind)
  );

  // Expected {R, jump_kind} straight from the opcode table
  function automatic logic [6:0] ref_class(input logic [31:0] i);
    logic [4:0] opc;
    opc = i[31:27];
    case (opc)
      5'b01101: return {i[14:10], 2'd1};
      5'b01110: return {i[14:10], 2'd2};
      5'b10000: return {i[14:10], 2'd3};
      default:  return 7'd0;
    endcase
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.addr  = $urandom;
    b.immed = $urandom;
    b.inst  = $urandom;
    b.rd1   = $urandom;
    b.rd2   = $urandom;
    case ($urandom % 5)
      0: b.inst[31:27] = 5'b01101;
      1: b.inst[31:27] = 5'b01110;
      2: b.inst[31:27] = 5'b10000;
      default: ;
    endcase
    return b;
  endfunction

  task automatic drive();
    addr  = cur_in.addr;
    immed = cur_in.immed;
    inst  = cur_in.inst;
    rd1   = cur_in.rd1;
    rd2   = cur_in.rd2;
  endtask

  // One clock: advance the FIFO model with the applied inputs, settle 1ns past the edge
  task automatic tick();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && out_ready;
    if (!rst) begin
      q.delete();
      zero_all   = 1;
      class_zero = 1;
    end else if (flush) begin
      q.delete();
      class_zero = 1;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(cur_in);
      if (acc) begin
        zero_all   = 0;
        class_zero = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0; flush = 0; out_ready = 1; in_valid = 1;
    cur_in = rand_beat(); drive();
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (R !== 5'd0 || jump_kind !== 2'd0) begin n_fail++; $display("FAIL reset_class: got R=%0d kind=%0d want 0/0", R, jump_kind); end
    n_checks++;
    if ({stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2} !== 160'd0) begin
      n_fail++; $display("FAIL reset_payload: got %h want 0", {stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2});
    end
    rst = 1; in_valid = 0;
    tick();
  endtask

  task automatic test_streaming();
    beat_t b[8];
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      b[k] = rand_beat();
      cur_in = b[k]; drive(); in_valid = 1;
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready); end
      n_checks++;
      if ({stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2} !== b[k]) begin
        n_fail++; $display("FAIL stream_payload[%0d]: got %h want %h", k,
                           {stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2}, b[k]);
      end
      n_checks++; if ({R, jump_kind} !== ref_class(b[k].inst)) begin n_fail++; $display("FAIL stream_class[%0d]: got %h want %h", k, {R, jump_kind}, ref_class(b[k].inst)); end
    end
    in_valid = 0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    beat_t b[3];
    int    idx;
    for (int k = 0; k < 3; k++) b[k] = rand_beat();
    out_ready = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      bit will_accept;
      cur_in = b[idx]; drive(); in_valid = 1;
      will_accept = (q.size() < 2);
      tick();
      if (will_accept && idx < 2) idx++;
      n_checks++; if (in_ready !== (c == 0)) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, (c == 0)); end
      n_checks++;
      if (out_valid !== 1'b1 || stored_inst !== b[0].inst || stored_addr !== b[0].addr) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b inst=%h want v=1 inst=%h", c, out_valid, stored_inst, b[0].inst);
      end
    end
    out_ready = 1;
    tick();
    n_checks++; if (stored_inst !== b[1].inst || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release1: got inst=%h rdy=%b want %h/1", stored_inst, in_ready, b[1].inst); end
    tick();
    n_checks++; if (stored_inst !== b[2].inst || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release2: got inst=%h v=%b want %h/1", stored_inst, out_valid, b[2].inst); end
    in_valid = 0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_jump_decode();
    logic [31:0] insts [4];
    logic [4:0]  exp_r [4];
    logic [1:0]  exp_k [4];
    insts[0] = 32'h6800_2C00; exp_r[0] = 5'd11; exp_k[0] = 2'd1;
    insts[1] = 32'h8000_1400; exp_r[1] = 5'd5;  exp_k[1] = 2'd3;
    insts[2] = 32'h7000_7C00; exp_r[2] = 5'd31; exp_k[2] = 2'd2;
    insts[3] = 32'h0800_2C00; exp_r[3] = 5'd0;  exp_k[3] = 2'd0;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      cur_in = rand_beat(); cur_in.inst = insts[k]; drive(); in_valid = 1;
      tick();
      n_checks++;
      if (R !== exp_r[k] || jump_kind !== exp_k[k]) begin
        n_fail++; $display("FAIL jump_decode[%0d]: got R=%0d kind=%0d want R=%0d kind=%0d", k, R, jump_kind, exp_r[k], exp_k[k]);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      cur_in = rand_beat(); cur_in.inst[31:27] = 5'b01101; drive(); in_valid = 1;
      tick();
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefill: got in_ready=%b want 0", in_ready); end
    cur_in = rand_beat(); drive(); in_valid = 1; flush = 1;
    tick();
    flush = 0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (R !== 5'd0 || jump_kind !== 2'd0) begin n_fail++; $display("FAIL flush_class: got R=%0d kind=%0d want 0/0", R, jump_kind); end
    in_valid = 0; out_ready = 1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      cur_in = rand_beat(); cur_in.inst[31:27] = 5'b10000; drive(); in_valid = 1;
      tick();
    end
    rst = 0; flush = 0;
    tick();
    rst = 1; in_valid = 0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_state: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_checks++;
    if ({stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2, R, jump_kind} !== 167'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h want 0",
                         {stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2, R, jump_kind});
    end
  endtask

  task automatic test_random();
    bit holding;
    holding = 0;
    for (int c = 0; c < 600; c++) begin
      bit will_accept;
      if (!holding) begin
        cur_in   = rand_beat();
        in_valid = ($urandom % 4) != 0;
      end
      drive();
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      will_accept = in_valid && (q.size() < 2);
      tick();
      holding = in_valid && !will_accept && !flush;
      flush   = 0;
      n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b want %b", c, out_valid, (q.size() > 0)); end
      n_checks++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, (q.size() < 2)); end
      if (q.size() > 0) begin
        n_checks++;
        if ({stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2} !== q[0] ||
            {R, jump_kind} !== ref_class(q[0].inst)) begin
          n_fail++; $display("FAIL rand_payload[%0d]: got %h/%h want %h/%h", c,
                             {stored_addr, stored_immed, stored_inst, stored_rd1, stored_rd2}, {R, jump_kind},
                             q[0], ref_class(q[0].inst));
        end
      end else if (class_zero) begin
        n_checks++; if ({R, jump_kind} !== 7'd0) begin n_fail++; $display("FAIL rand_flush_class[%0d]: got %h want 0", c, {R, jump_kind}); end
      end
    end
    in_valid = 0;
    tick();
  endtask

  initial begin
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    addr = '0; immed = '0; inst = '0; rd1 = '0; rd2 = '0;
    cur_in = '0; zero_all = 1; class_zero = 1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_jump_decode();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
